mb_ser_wide: RTL and testbench

//  Parametrised multi-lane coefficient serializer; successor to the single-lane macroblock serializer.

---
 rtl/mb_ser_wide.sv | 157 +++++++++++++++
 tb/tb_mb_ser_wide.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_ser_wide.sv
// mb_ser_wide: multi-lane coefficient serializer.
// Pops one block of N (sign,pos) entries from a show-ahead buffer and
// emits up to LANES entries per beat into the sign/pos FIFOs.
// Ports:
//   clk, rst (sync, active-low), clk_en (global hold)
//   sign_in/pos_in/size_in/slice_end : block from buffer, valid while !mb_empty
//   sign_afull/pos_afull             : downstream back-pressure
//   mb_rd                            : combinational pop strobe
//   sign_out/pos_out/lane_vld/mb_wr/blk_last/slice_end_out : registered beat
module mb_ser_wide #(
   parameter int N     = 64,
   parameter int POS_W = $clog2(N),
   parameter int SZ_W  = $clog2(N+1),
   parameter int LANES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic [N-1:0]           sign_in,
   input  logic [N*POS_W-1:0]     pos_in,
   input  logic [SZ_W-1:0]        size_in,
   input  logic                   mb_empty,
   input  logic                   slice_end,
   input  logic                   sign_afull,
   input  logic                   pos_afull,
   output logic                   mb_rd,
   output logic [LANES-1:0]       sign_out,
   output logic [LANES*POS_W-1:0] pos_out,
   output logic [LANES-1:0]       lane_vld,
   output logic                   mb_wr,
   output logic                   blk_last,
   output logic                   slice_end_out
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                 state_q, state_d;
   logic [SZ_W-1:0]        rem_q, rem_d;
   logic [SZ_W-1:0]        idx_q, idx_d;
   logic                   slf_q, slf_d;
   logic [N-1:0]           sign_buf_q, sign_buf_d;
   logic [POS_W-1:0]       pos_buf_q [N];
   logic [POS_W-1:0]       pos_buf_d [N];
   logic [LANES-1:0]       sign_out_q, sign_out_d;
   logic [LANES*POS_W-1:0] pos_out_q, pos_out_d;
   logic [LANES-1:0]       lane_vld_q, lane_vld_d;
   logic                   mb_wr_q, mb_wr_d;
   logic                   blk_last_q, blk_last_d;
   logic                   slice_end_out_q, slice_end_out_d;

   logic            stall;
   logic            last;
   logic            beat;
   logic [SZ_W-1:0] k;
   logic [POS_W-1:0] sl;

   always_comb begin
      stall = sign_afull | pos_afull;
      // remaining entries fit in this beat
      last  = (state_q == EMIT) && (rem_q <= SZ_W'(LANES));
      k     = (rem_q < SZ_W'(LANES)) ? rem_q : SZ_W'(LANES);
      beat  = clk_en & ~stall & (state_q == EMIT);
      mb_rd = clk_en & ~mb_empty & ~stall & ((state_q == IDLE) | last);

      state_d         = state_q;
      rem_d           = rem_q;
      idx_d           = idx_q;
      slf_d           = slf_q;
      sign_buf_d      = sign_buf_q;
      pos_buf_d       = pos_buf_q;
      sign_out_d      = sign_out_q;
      pos_out_d       = pos_out_q;
      lane_vld_d      = lane_vld_q;
      mb_wr_d         = mb_wr_q;
      blk_last_d      = blk_last_q;
      slice_end_out_d = slice_end_out_q;
      sl              = '0;

      // strobes are single-cycle unless the whole block is frozen
      if (clk_en) begin
         mb_wr_d         = 1'b0;
         lane_vld_d      = '0;
         blk_last_d      = 1'b0;
         slice_end_out_d = 1'b0;
      end

      if (beat) begin
         // an empty block only produces a beat when it ends a slice
         if ((k != '0) || slf_q) begin
            mb_wr_d         = 1'b1;
            blk_last_d      = last;
            slice_end_out_d = last & slf_q;
            for (int i = 0; i < LANES; i++) begin
               sl = POS_W'(idx_q + SZ_W'(i));
               if (SZ_W'(i) < k) begin
                  lane_vld_d[i] = 1'b1;
                  sign_out_d[i] = sign_buf_q[sl];
                  pos_out_d[i*POS_W +: POS_W] = pos_buf_q[sl];
               end else begin
                  sign_out_d[i] = 1'b0;
                  pos_out_d[i*POS_W +: POS_W] = '0;
               end
            end
         end
         idx_d = idx_q + k;
         rem_d = rem_q - k;
         if (last) state_d = IDLE;
      end

      // capture overrides the end-of-block transition
      if (mb_rd) begin
         sign_buf_d = sign_in;
         for (int s = 0; s < N; s++)
            pos_buf_d[s] = pos_in[s*POS_W +: POS_W];
         rem_d   = (size_in > SZ_W'(N)) ? SZ_W'(N) : size_in;
         idx_d   = '0;
         slf_d   = slice_end;
         state_d = EMIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         idx_q           <= '0;
         slf_q           <= 1'b0;
         sign_out_q      <= '0;
         pos_out_q       <= '0;
         lane_vld_q      <= '0;
         mb_wr_q         <= 1'b0;
         blk_last_q      <= 1'b0;
         slice_end_out_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         idx_q           <= idx_d;
         slf_q           <= slf_d;
         sign_buf_q      <= sign_buf_d;
         pos_buf_q       <= pos_buf_d;
         sign_out_q      <= sign_out_d;
         pos_out_q       <= pos_out_d;
         lane_vld_q      <= lane_vld_d;
         mb_wr_q         <= mb_wr_d;
         blk_last_q      <= blk_last_d;
         slice_end_out_q <= slice_end_out_d;
      end
   end

   assign sign_out      = sign_out_q;
   assign pos_out       = pos_out_q;
   assign lane_vld      = lane_vld_q;
   assign mb_wr         = mb_wr_q;
   assign blk_last      = blk_last_q;
   assign slice_end_out = slice_end_out_q;

endmodule

// File: tb/tb_mb_ser_wide.sv
// tb_mb_ser_wide: randomized bench for mb_ser_wide against a
// block-to-beat-list reference model plus literal pins.
module tb_mb_ser_wide;
   localparam int N     = 64;
   localparam int POS_W = 6;
   localparam int SZ_W  = 7;
   localparam int L     = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clk_en = 1'b0;
   logic [N-1:0] sign_in = '0;
   logic [N*POS_W-1:0] pos_in = '0;
   logic [SZ_W-1:0] size_in = '0;
   logic mb_empty = 1'b1;
   logic slice_end = 1'b0;
   logic sign_afull = 1'b0;
   logic pos_afull = 1'b0;
   logic mb_rd;
   logic [L-1:0] sign_out;
   logic [L*POS_W-1:0] pos_out;
   logic [L-1:0] lane_vld;
   logic mb_wr, blk_last, slice_end_out;

   always #5 clk = ~clk;

   mb_ser_wide #(.N(N), .LANES(L)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .sign_in(sign_in), .pos_in(pos_in), .size_in(size_in),
      .mb_empty(mb_empty), .slice_end(slice_end),
      .sign_afull(sign_afull), .pos_afull(pos_afull),
      .mb_rd(mb_rd), .sign_out(sign_out), .pos_out(pos_out),
      .lane_vld(lane_vld), .mb_wr(mb_wr), .blk_last(blk_last),
      .slice_end_out(slice_end_out)
   );

   typedef struct {
      logic [N-1:0]       sg;
      logic [N*POS_W-1:0] ps;
      int                 sz;
      bit                 se;
   } blk_t;

   typedef struct {
      bit                 wr;
      logic [L-1:0]       vld;
      logic [L-1:0]       sg;
      logic [L*POS_W-1:0] ps;
      bit                 last;
      bit                 se;
   } beat_t;

   blk_t  buf_q[$];
   beat_t pend[$];
   beat_t log_q[$];
   beat_t ref_q[$];
   beat_t exp_o = '{default: 0};
   bit    exp_rd = 1'b0;
   bit    chk_on = 1'b0;
   bit    last_ce = 1'b0;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // reference: a block becomes its list of beats
   function automatic void expand(blk_t b);
      int n;
      beat_t bt;
      n = (b.sz > N) ? N : b.sz;
      if (n == 0) begin
         bt = '{default: 0};
         bt.wr = b.se;
         bt.last = b.se;
         bt.se = b.se;
         pend.push_back(bt);
         return;
      end
      for (int s = 0; s < n; s += L) begin
         bt = '{default: 0};
         bt.wr = 1'b1;
         for (int j = 0; j < L; j++)
            if (s + j < n) begin
               bt.vld[j] = 1'b1;
               bt.sg[j] = b.sg[s+j];
               bt.ps[j*POS_W +: POS_W] = b.ps[(s+j)*POS_W +: POS_W];
            end
         bt.last = (s + L >= n);
         bt.se = bt.last & b.se;
         pend.push_back(bt);
      end
   endfunction

   function automatic blk_t mk(int sz, bit se, int mode, logic [N-1:0] sg);
      blk_t b;
      int v;
      b.sz = sz;
      b.se = se;
      b.sg = sg;
      b.ps = '0;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: v = i;
            1: v = 2 + 3 * i;
            2: v = 63 - i;
            default: v = int'($urandom_range(0, 63));
         endcase
         b.ps[i*POS_W +: POS_W] = POS_W'(v);
      end
      return b;
   endfunction

   // one clock: drive, then advance the model on the edge
   task automatic step(bit r, bit ce, bit sa, bit pa);
      beat_t b;
      blk_t  k;
      rst = r;
      clk_en = ce;
      sign_afull = sa;
      pos_afull = pa;
      if (buf_q.size() != 0) begin
         mb_empty = 1'b0;
         sign_in = buf_q[0].sg;
         pos_in = buf_q[0].ps;
         size_in = SZ_W'(buf_q[0].sz);
         slice_end = buf_q[0].se;
      end else begin
         mb_empty = 1'b1;
         size_in = SZ_W'($urandom_range(0, 100));
         slice_end = 1'($urandom_range(0, 1));
      end
      exp_rd = ce && (buf_q.size() != 0) && !(sa || pa) && (pend.size() <= 1);
      @(posedge clk);
      last_ce = ce;
      if (!r) begin
         pend.delete();
         exp_o = '{default: 0};
      end else if (ce) begin
         if (!(sa || pa) && pend.size() != 0) begin
            b = pend.pop_front();
            if (b.wr) exp_o = b;
            else begin
               exp_o.wr = 0;
               exp_o.vld = '0;
               exp_o.last = 0;
               exp_o.se = 0;
            end
         end else begin
            exp_o.wr = 0;
            exp_o.vld = '0;
            exp_o.last = 0;
            exp_o.se = 0;
         end
      end
      if (exp_rd) begin
         k = buf_q.pop_front();
         if (r) expand(k);
      end
      #1;
      cyc++;
   endtask

   task automatic drain(int lim);
      int i;
      i = 0;
      while ((buf_q.size() != 0 || pend.size() != 0) && i < lim) begin
         step(1, 1, 0, 0);
         i++;
      end
      if (buf_q.size() != 0 || pend.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d blocks %0d beats left", buf_q.size(), pend.size());
      end
      repeat (2) step(1, 1, 0, 0);
   endtask

   always @(negedge clk) begin
      beat_t o;
      if (chk_on) begin
         chk("mb_rd", 64'(mb_rd), 64'(exp_rd));
         chk("mb_wr", 64'(mb_wr), 64'(exp_o.wr));
         chk("lane_vld", 64'(lane_vld), 64'(exp_o.vld));
         chk("sign_out", 64'(sign_out), 64'(exp_o.sg));
         chk("pos_out", 64'(pos_out), 64'(exp_o.ps));
         chk("blk_last", 64'(blk_last), 64'(exp_o.last));
         chk("slice_end_out", 64'(slice_end_out), 64'(exp_o.se));
         if (mb_wr === 1'b1 && last_ce) begin
            o.wr = 1;
            o.vld = lane_vld;
            o.sg = sign_out;
            o.ps = pos_out;
            o.last = blk_last;
            o.se = slice_end_out;
            log_q.push_back(o);
         end
      end
   end

   initial begin
      int nl;
      step(0, 1, 0, 0);
      chk_on = 1'b1;
      step(0, 1, 0, 0);

      // single entry
      log_q.delete();
      buf_q.push_back(mk(1, 0, 0, {16{4'h5}}));
      drain(100);
      chk("t1_beats", 64'(log_q.size()), 64'd1);
      chk("t1_vld", 64'(log_q[0].vld), 64'b01);
      chk("t1_pos", 64'(log_q[0].ps), 64'd0);
      chk("t1_sign", 64'(log_q[0].sg), 64'b01);
      chk("t1_last", 64'(log_q[0].last), 64'd1);

      // full block then 17-entry slice-end block, back to back
      log_q.delete();
      buf_q.push_back(mk(64, 0, 0, {$urandom, $urandom}));
      buf_q.push_back(mk(17, 1, 1, {$urandom, $urandom}));
      drain(200);
      chk("t2_beats", 64'(log_q.size()), 64'd41);
      chk("t2_first_pos", 64'(log_q[0].ps), {52'd0, 6'd1, 6'd0});
      chk("t2_32_pos", 64'(log_q[31].ps), {52'd0, 6'd63, 6'd62});
      chk("t2_32_last", 64'(log_q[31].last), 64'd1);
      nl = 0;
      for (int i = 0; i < 31; i++) nl += int'(log_q[i].last);
      chk("t2_early_last", 64'(nl), 64'd0);
      chk("t3_vld", 64'(log_q[40].vld), 64'b01);
      chk("t3_pos0", 64'(log_q[40].ps[5:0]), 64'd50);
      chk("t3_last", 64'(log_q[40].last), 64'd1);
      chk("t3_se", 64'(log_q[40].se), 64'd1);
      ref_q = log_q;

      // empty blocks
      log_q.delete();
      buf_q.push_back(mk(0, 1, 0, '0));
      buf_q.push_back(mk(0, 0, 0, '0));
      buf_q.push_back(mk(0, 1, 0, '0));
      drain(100);
      chk("t4_beats", 64'(log_q.size()), 64'd2);
      chk("t4_vld", 64'(log_q[0].vld), 64'd0);
      chk("t4_se", 64'(log_q[0].se), 64'd1);

      // periodic stalls: same beats as the stall-free run
      log_q.delete();
      buf_q.push_back(mk(64, 0, 0, ref_q[0].sg == 2'b00 ? 64'd0 : {$urandom, $urandom}));
      for (int c = 0; c < 300 && (buf_q.size() != 0 || pend.size() != 0); c++)
         step(1, 1, (c % 4) == 3, (c % 5) == 4);
      drain(100);
      chk("t5_beats", 64'(log_q.size()), 64'd32);
      for (int i = 0; i < 32; i++)
         chk("t5_pos", 64'(log_q[i].ps), 64'(ref_q[i].ps));

      // reset mid-block, then clk_en gaps
      buf_q.push_back(mk(64, 1, 2, {$urandom, $urandom}));
      repeat (5) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("t6_rst_wr", 64'(mb_wr), 64'd0);
      chk("t6_rst_vld", 64'(lane_vld), 64'd0);
      chk("t6_rst_pos", 64'(pos_out), 64'd0);
      log_q.delete();
      buf_q.push_back(mk(4, 0, 0, {$urandom, $urandom}));
      for (int c = 0; c < 30; c++) step(1, (c % 3) != 1, 0, 0);
      drain(50);
      chk("t6_beats", 64'(log_q.size()), 64'd2);
      chk("t6_pos0", 64'(log_q[0].ps), {52'd0, 6'd1, 6'd0});
      chk("t6_pos1", 64'(log_q[1].ps), {52'd0, 6'd3, 6'd2});

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (buf_q.size() < 3 && $urandom_range(0, 3) == 0)
            buf_q.push_back(mk(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 80)),
                               1'($urandom_range(0, 1)), 3, {$urandom, $urandom}));
         step($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      end
      drain(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule
